// File: rtl/gpu_cmd_pkg.sv
// Shared types and defaults for the GPU command scheduler.
package gpu_cmd_pkg;
   typedef enum logic [1:0] {
      PASS  = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } sched_state_t;

   localparam int DEF_CMD_W   = 16;
   localparam int DEF_DATA_W  = 16;
   localparam int DEF_DEPTH   = 16;
   localparam int RD_FLAG_IDX = DEF_CMD_W - 1;

   // Read flag is always the MSB of the command word.
   function automatic int rd_flag_idx(input int cmd_w);
      return cmd_w - 1;
   endfunction
endpackage

// File: rtl/gpu_cmd_scheduler_if.sv
// Valid/ready command stream carrying a command word and its data word.
interface gpu_cmd_scheduler_if
   import gpu_cmd_pkg::*;
#(
   parameter int CMD_W  = DEF_CMD_W,
   parameter int DATA_W = DEF_DATA_W
);
   logic              valid;
   logic              ready;
   logic [CMD_W-1:0]  cmd;
   logic [DATA_W-1:0] data;

   modport master (output valid, cmd, data, input ready);
   modport slave  (input valid, cmd, data, output ready);
endinterface

// File: rtl/gpu_cmd_fifo.sv
// Synchronous write-hold FIFO; pointers carry an extra wrap bit so full/empty need no flag.
module gpu_cmd_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 16,
   parameter int LVL_W = $clog2(DEPTH) + 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic [W-1:0]     i_wdata,
   input  logic             i_pop,
   output logic [W-1:0]     o_rdata,
   output logic             o_full,
   output logic             o_empty,
   output logic [LVL_W-1:0] o_level
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] r_mem [DEPTH];
   logic [AW:0]  r_wr_ptr;
   logic [AW:0]  r_rd_ptr;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (i_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
   end

   assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];
   assign o_level = LVL_W'(r_wr_ptr - r_rd_ptr);
   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (o_level == LVL_W'(DEPTH));
endmodule

// File: rtl/gpu_cmd_scheduler.sv
// Orders host commands around frame renders: reads bypass, writes are held and drained in order.
// Optional GPU_CMD_STATS_EN adds max_level and stall_cnt statistics outputs.
module gpu_cmd_scheduler
   import gpu_cmd_pkg::*;
#(
   parameter int CMD_W  = DEF_CMD_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int LVL_W  = $clog2(DEPTH) + 1
) (
   input  logic                cmd_clk_in,
   input  logic                cmd_rst_n_in,
   gpu_cmd_scheduler_if.slave  in_if,
   gpu_cmd_scheduler_if.master out_if,
   input  logic                render_active,
   output logic                frame_clear,
   output logic [LVL_W-1:0]    fifo_level,
   output logic                late_render
`ifdef GPU_CMD_STATS_EN
   ,
   output logic [LVL_W-1:0]    max_level,
   output logic [31:0]         stall_cnt
`endif
);
   localparam int RD_BIT = rd_flag_idx(CMD_W);

   sched_state_t r_state, w_nxt_state;
   logic r_late;
   logic r_vld_p1;
   logic [CMD_W-1:0]  r_cmd_p1;
   logic [DATA_W-1:0] r_data_p1;

   logic w_out_free, w_is_rd, w_in_ready, w_load_in, w_push, w_pop, w_set_late;
   logic w_full, w_empty;
   logic [LVL_W-1:0] w_fifo_level;
   logic [CMD_W+DATA_W-1:0] w_fifo_head;

   gpu_cmd_fifo #(.W(CMD_W + DATA_W), .DEPTH(DEPTH), .LVL_W(LVL_W)) u_fifo (
      .i_clk   (cmd_clk_in),
      .i_rst_n (cmd_rst_n_in),
      .i_push  (w_push),
      .i_wdata ({in_if.cmd, in_if.data}),
      .i_pop   (w_pop),
      .o_rdata (w_fifo_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (w_fifo_level)
   );

   assign w_out_free = !r_vld_p1 || out_if.ready;
   assign w_is_rd    = in_if.cmd[RD_BIT];

   always_comb begin
      w_nxt_state = r_state;
      w_in_ready  = 1'b0;
      w_load_in   = 1'b0;
      w_push      = 1'b0;
      w_pop       = 1'b0;
      w_set_late  = 1'b0;
      unique case (r_state)
         PASS: begin
            w_in_ready = w_out_free;
            w_load_in  = in_if.valid && w_out_free;
            if (render_active) w_nxt_state = HOLD;
         end
         HOLD: begin
            if (w_is_rd) begin
               w_in_ready = w_out_free;
               w_load_in  = in_if.valid && w_out_free;
            end else begin
               w_in_ready = !w_full;
               w_push     = in_if.valid && !w_full;
            end
            // A write pushed on the exit cycle still has to be drained.
            if (!render_active) w_nxt_state = (w_empty && !w_push) ? PASS : DRAIN;
         end
         DRAIN: begin
            if (render_active && !w_empty) begin
               w_nxt_state = HOLD;
               w_set_late  = 1'b1;
            end else if (w_empty) begin
               w_nxt_state = PASS;
            end else begin
               w_pop = w_out_free;
               if (w_out_free && w_fifo_level == LVL_W'(1)) w_nxt_state = PASS;
            end
         end
         default: w_nxt_state = PASS;
      endcase
   end

   always_ff @(posedge cmd_clk_in or negedge cmd_rst_n_in) begin
      if (!cmd_rst_n_in) begin
         r_state <= PASS;
         r_late  <= 1'b0;
      end else begin
         r_state <= w_nxt_state;
         if (w_set_late) r_late <= 1'b1;
      end
   end

   // Stage p0 -> p1: single output register fed by the input or the FIFO head
   always_ff @(posedge cmd_clk_in or negedge cmd_rst_n_in) begin
      if (!cmd_rst_n_in) begin
         r_vld_p1  <= 1'b0;
         r_cmd_p1  <= '0;
         r_data_p1 <= '0;
      end else if (w_load_in) begin
         r_vld_p1  <= 1'b1;
         r_cmd_p1  <= in_if.cmd;
         r_data_p1 <= in_if.data;
      end else if (w_pop) begin
         r_vld_p1               <= 1'b1;
         {r_cmd_p1, r_data_p1}  <= w_fifo_head;
      end else if (out_if.ready) begin
         r_vld_p1 <= 1'b0;
      end
   end

   assign in_if.ready  = w_in_ready;
   assign out_if.valid = r_vld_p1;
   assign out_if.cmd   = r_cmd_p1;
   assign out_if.data  = r_data_p1;
   assign frame_clear  = (r_state == PASS) && w_empty;
   assign fifo_level   = w_fifo_level;
   assign late_render  = r_late;

`ifdef GPU_CMD_STATS_EN
   logic [LVL_W-1:0] r_max_level;
   logic [31:0]      r_stall_cnt;

   always_ff @(posedge cmd_clk_in or negedge cmd_rst_n_in) begin
      if (!cmd_rst_n_in) begin
         r_max_level <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (w_fifo_level > r_max_level) r_max_level <= w_fifo_level;
         if (in_if.valid && !w_in_ready && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign max_level = r_max_level;
   assign stall_cnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_gpu_cmd_scheduler.sv
// Directed bench for gpu_cmd_scheduler built with DEPTH=4.
module tb_gpu_cmd_scheduler;
   localparam int CW    = 16;
   localparam int DW    = 16;
   localparam int DEPTH = 4;
   localparam int LW    = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic render = 1'b0;
   logic frame_clear, late_render;
   logic [LW-1:0] fifo_level;
`ifdef GPU_CMD_STATS_EN
   logic [LW-1:0] max_level;
   logic [31:0]   stall_cnt;
`endif
   int n_tests = 0;
   int n_fail  = 0;

   gpu_cmd_scheduler_if #(.CMD_W(CW), .DATA_W(DW)) in_if ();
   gpu_cmd_scheduler_if #(.CMD_W(CW), .DATA_W(DW)) out_if ();

   always #5 clk = ~clk;

   gpu_cmd_scheduler #(.CMD_W(CW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
      .cmd_clk_in    (clk),
      .cmd_rst_n_in  (rst_n),
      .in_if         (in_if),
      .out_if        (out_if),
      .render_active (render),
      .frame_clear   (frame_clear),
      .fifo_level    (fifo_level),
      .late_render   (late_render)
`ifdef GPU_CMD_STATS_EN
      ,
      .max_level     (max_level),
      .stall_cnt     (stall_cnt)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [15:0] c, input logic [15:0] d);
      in_if.valid = v;
      in_if.cmd   = c;
      in_if.data  = d;
   endtask

   task automatic test_reset();
      #1;
      n_tests++; if (out_if.valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", out_if.valid); end
      n_tests++; if (out_if.cmd !== 16'h0 || out_if.data !== 16'h0) begin n_fail++; $display("FAIL rst_outdata: got %h/%h want 0/0", out_if.cmd, out_if.data); end
      n_tests++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL rst_level: got %0d want 0", fifo_level); end
      n_tests++; if (late_render !== 1'b0 || frame_clear !== 1'b1) begin n_fail++; $display("FAIL rst_flags: late=%b clear=%b want 0/1", late_render, frame_clear); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_pass_through();
      drive(1'b1, 16'h0005, 16'h1234);
      #1;
      n_tests++; if (in_if.ready !== 1'b1) begin n_fail++; $display("FAIL pt_ready: got %b want 1", in_if.ready); end
      tick();
      drive(1'b0, 16'h0, 16'h0);
      n_tests++; if (out_if.valid !== 1'b1 || out_if.cmd !== 16'h0005 || out_if.data !== 16'h1234) begin n_fail++; $display("FAIL pt_out: got %b %h/%h want 1 0005/1234", out_if.valid, out_if.cmd, out_if.data); end
      n_tests++; if (frame_clear !== 1'b1) begin n_fail++; $display("FAIL pt_clear: got %b want 1", frame_clear); end
      tick();
      n_tests++; if (out_if.valid !== 1'b0) begin n_fail++; $display("FAIL pt_idle: got %b want 0", out_if.valid); end
   endtask

   task automatic test_hold_read();
      render = 1'b1;
      tick();
      n_tests++; if (frame_clear !== 1'b0) begin n_fail++; $display("FAIL hr_clear: got %b want 0", frame_clear); end
      drive(1'b1, 16'h0005, 16'h7777);
      tick();
      n_tests++; if (out_if.valid !== 1'b0 || fifo_level !== 3'd1) begin n_fail++; $display("FAIL hr_push: valid=%b level=%0d want 0/1", out_if.valid, fifo_level); end
      drive(1'b1, 16'h8005, 16'h00AA);
      tick();
      drive(1'b0, 16'h0, 16'h0);
      n_tests++; if (out_if.valid !== 1'b1 || out_if.cmd !== 16'h8005 || out_if.data !== 16'h00AA) begin n_fail++; $display("FAIL hr_read: got %b %h/%h want 1 8005/00aa", out_if.valid, out_if.cmd, out_if.data); end
      n_tests++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL hr_level: got %0d want 1", fifo_level); end
      render = 1'b0;
      tick();
      n_tests++; if (out_if.valid !== 1'b0) begin n_fail++; $display("FAIL hr_drain_idle: got %b want 0", out_if.valid); end
      tick();
      n_tests++; if (out_if.cmd !== 16'h0005 || out_if.data !== 16'h7777 || frame_clear !== 1'b1) begin n_fail++; $display("FAIL hr_drain: got %h/%h clear=%b want 0005/7777 1", out_if.cmd, out_if.data, frame_clear); end
      tick();
   endtask

   task automatic test_drain_order();
      render = 1'b1;
      tick();
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 16'(i), 16'(16'h0100 + i));
         tick();
      end
      drive(1'b0, 16'h0, 16'h0);
      n_tests++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL do_level: got %0d want 4", fifo_level); end
      render = 1'b0;
      tick();
      for (int i = 1; i <= 4; i++) begin
         tick();
         n_tests++; if (out_if.valid !== 1'b1 || out_if.cmd !== 16'(i) || out_if.data !== 16'(16'h0100 + i)) begin n_fail++; $display("FAIL do_pop%0d: got %b %h/%h want 1 %h/%h", i, out_if.valid, out_if.cmd, out_if.data, 16'(i), 16'(16'h0100 + i)); end
         n_tests++; if (frame_clear !== (i == 4)) begin n_fail++; $display("FAIL do_clear%0d: got %b want %b", i, frame_clear, (i == 4)); end
      end
      tick();
   endtask

   task automatic test_full_backpressure();
      render = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 16'(16'h0011 + i), 16'hBEEF);
         tick();
      end
      drive(1'b1, 16'h0015, 16'hCAFE);
      #1;
      n_tests++; if (in_if.ready !== 1'b0 || fifo_level !== 3'd4) begin n_fail++; $display("FAIL fb_full: ready=%b level=%0d want 0/4", in_if.ready, fifo_level); end
      render = 1'b0;
      tick();
      n_tests++; if (in_if.ready !== 1'b0) begin n_fail++; $display("FAIL fb_drain_ready: got %b want 0", in_if.ready); end
      for (int i = 0; i < 4; i++) begin
         tick();
         n_tests++; if (out_if.cmd !== 16'(16'h0011 + i)) begin n_fail++; $display("FAIL fb_pop%0d: got %h want %h", i, out_if.cmd, 16'(16'h0011 + i)); end
      end
      n_tests++; if (in_if.ready !== 1'b1 || fifo_level !== 3'd0) begin n_fail++; $display("FAIL fb_pass_ready: ready=%b level=%0d want 1/0", in_if.ready, fifo_level); end
      tick();
      drive(1'b0, 16'h0, 16'h0);
      n_tests++; if (out_if.valid !== 1'b1 || out_if.cmd !== 16'h0015 || out_if.data !== 16'hCAFE) begin n_fail++; $display("FAIL fb_fifth: got %b %h/%h want 1 0015/cafe", out_if.valid, out_if.cmd, out_if.data); end
      tick();
`ifdef GPU_CMD_STATS_EN
      n_tests++; if (max_level !== 3'd4) begin n_fail++; $display("FAIL fb_max_level: got %0d want 4", max_level); end
`endif
   endtask

   task automatic test_late_render();
      render = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 16'(16'h0021 + i), 16'(16'h0A00 + i));
         tick();
      end
      drive(1'b0, 16'h0, 16'h0);
      render = 1'b0;
      tick();
      n_tests++; if (late_render !== 1'b0) begin n_fail++; $display("FAIL lr_pre: got %b want 0", late_render); end
      tick();
      n_tests++; if (out_if.cmd !== 16'h0021 || fifo_level !== 3'd2) begin n_fail++; $display("FAIL lr_first: got %h level=%0d want 0021/2", out_if.cmd, fifo_level); end
      render = 1'b1;
      tick();
      n_tests++; if (late_render !== 1'b1 || fifo_level !== 3'd2 || out_if.valid !== 1'b0) begin n_fail++; $display("FAIL lr_halt: late=%b level=%0d valid=%b want 1/2/0", late_render, fifo_level, out_if.valid); end
      tick();
      n_tests++; if (fifo_level !== 3'd2 || out_if.valid !== 1'b0) begin n_fail++; $display("FAIL lr_hold: level=%0d valid=%b want 2/0", fifo_level, out_if.valid); end
      render = 1'b0;
      tick();
      tick();
      n_tests++; if (out_if.cmd !== 16'h0022 || out_if.data !== 16'h0A01) begin n_fail++; $display("FAIL lr_second: got %h/%h want 0022/0a01", out_if.cmd, out_if.data); end
      tick();
      n_tests++; if (out_if.cmd !== 16'h0023 || frame_clear !== 1'b1 || late_render !== 1'b1) begin n_fail++; $display("FAIL lr_third: got %h clear=%b late=%b want 0023/1/1", out_if.cmd, frame_clear, late_render); end
      tick();
   endtask

   task automatic test_back_to_back();
      out_if.ready = 1'b0;
      drive(1'b1, 16'h0041, 16'h4141);
      tick();
      drive(1'b1, 16'h0042, 16'h4242);
      #1;
      n_tests++; if (in_if.ready !== 1'b0 || out_if.cmd !== 16'h0041) begin n_fail++; $display("FAIL bb_stall: ready=%b cmd=%h want 0/0041", in_if.ready, out_if.cmd); end
      tick();
      n_tests++; if (out_if.valid !== 1'b1 || out_if.cmd !== 16'h0041) begin n_fail++; $display("FAIL bb_keep: got %b %h want 1 0041", out_if.valid, out_if.cmd); end
      out_if.ready = 1'b1;
      #1;
      n_tests++; if (in_if.ready !== 1'b1) begin n_fail++; $display("FAIL bb_ready: got %b want 1", in_if.ready); end
      tick();
      drive(1'b1, 16'h0043, 16'h4343);
      n_tests++; if (out_if.cmd !== 16'h0042) begin n_fail++; $display("FAIL bb_second: got %h want 0042", out_if.cmd); end
      tick();
      drive(1'b0, 16'h0, 16'h0);
      n_tests++; if (out_if.valid !== 1'b1 || out_if.cmd !== 16'h0043) begin n_fail++; $display("FAIL bb_third: got %b %h want 1 0043", out_if.valid, out_if.cmd); end
      tick();
   endtask

   task automatic test_reset_mid_drain();
      render = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 16'(16'h0031 + i), 16'h5555);
         tick();
      end
      drive(1'b0, 16'h0, 16'h0);
      render = 1'b0;
      tick();
      tick();
      n_tests++; if (out_if.cmd !== 16'h0031 || fifo_level !== 3'd2) begin n_fail++; $display("FAIL rm_pre: got %h level=%0d want 0031/2", out_if.cmd, fifo_level); end
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++; if (out_if.valid !== 1'b0 || out_if.cmd !== 16'h0) begin n_fail++; $display("FAIL rm_out: got %b %h want 0 0000", out_if.valid, out_if.cmd); end
      n_tests++; if (fifo_level !== 3'd0 || frame_clear !== 1'b1 || late_render !== 1'b0) begin n_fail++; $display("FAIL rm_flags: level=%0d clear=%b late=%b want 0/1/0", fifo_level, frame_clear, late_render); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      in_if.valid  = 1'b0;
      in_if.cmd    = '0;
      in_if.data   = '0;
      out_if.ready = 1'b1;
      test_reset();
      test_pass_through();
      test_hold_read();
      test_drain_order();
      test_full_backpressure();
      test_late_render();
      test_back_to_back();
      test_reset_mid_drain();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
